// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state, sizing helpers and bypass reset coefficients for the FIR blocks
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Sized so that TAPS full-scale products can never overflow the accumulator
    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

    function automatic int rst_coef(input int k);
        return k == 0 ? 1 : 0;
    endfunction

endpackage

// File: rtl/fir_mac_serial_if.sv
// fir_mac_serial_if: sample/result streams and coefficient write port of the serial FIR
interface fir_mac_serial_if import fir_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 8
);
    localparam int AW = clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_drop;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        input  in_ready, coef_drop, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        output in_ready, coef_drop, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/fir_sat_round.sv
// fir_sat_round: arithmetic shift, optional round-half-up (FIR_ROUND_EN) and saturation to OUT_W
module fir_sat_round #(
    parameter int ACC_W     = 19,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);
    logic signed [ACC_W:0] adj, shf;

`ifdef FIR_ROUND_EN
    localparam int RS = OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] BIAS = OUT_SHIFT > 0 ? (ACC_W+1)'(1) << RS : '0;
`else
    localparam logic signed [ACC_W:0] BIAS = '0;
`endif
    localparam logic signed [ACC_W:0] MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN = ~MAX;

    // One extra bit keeps the rounding bias from wrapping a full-scale accumulator
    always_comb begin
        adj = $signed({acc[ACC_W-1], acc}) + BIAS;
        shf = adj >>> OUT_SHIFT;
        sat = shf > MAX || shf < MIN;
        res = sat ? (shf > MAX ? MAX[OUT_W-1:0] : MIN[OUT_W-1:0]) : shf[OUT_W-1:0];
    end

endmodule

// File: rtl/fir_mac_serial.sv
// fir_mac_serial: N-tap FIR using one time-multiplexed MAC; rounding selectable via FIR_ROUND_EN
module fir_mac_serial import fir_pkg::*; #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fir_mac_serial_if.slave       bus,
    output logic                  busy
);
    localparam int AW    = clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

    state_t state, state_nx;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] h [TAPS];
    logic signed [ACC_W-1:0]  acc, acc_nx;
    logic signed [PW-1:0]     prod;
    logic signed [OUT_W-1:0]  res;
    logic [AW-1:0]            k;
    logic                     sat, last, accept, coef_ok;

    assign last    = k == AW'(TAPS - 1);
    assign accept  = bus.in_valid && state == IDLE;
    assign coef_ok = bus.coef_we && 32'(bus.coef_addr) < TAPS;
    assign prod    = x[k] * h[k];
    assign acc_nx  = acc + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (bus.in_valid ? MAC : IDLE) :
                   state == MAC  ? (last ? OUT : MAC) :
                   bus.out_ready ? IDLE : OUT;

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == OUT;
        busy          = state != IDLE;
    end

    // The result is registered from acc_nx on the final MAC edge, so OUT presents it immediately
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                h[i] <= COEF_W'(rst_coef(i));
            end
            acc           <= '0;
            k             <= '0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.coef_drop <= 1'b0;
        end else begin
            bus.coef_drop <= coef_ok && state == MAC;
            if (coef_ok && state != MAC) h[bus.coef_addr] <= bus.coef_wdata;
            if (accept) begin
                x[0] <= bus.in_data;
                for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
                acc <= '0;
                k   <= '0;
            end
            if (state == MAC) begin
                acc <= acc_nx;
                k   <= last ? '0 : k + 1'b1;
                if (last) begin
                    bus.out_data <= res;
                    bus.out_sat  <= sat;
                end
            end
        end

    fir_sat_round #(.ACC_W(ACC_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)) u_sat (
        .acc(acc_nx),
        .res(res),
        .sat(sat)
    );

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial: directed and randomised checks of fir_mac_serial against a sum-of-products model
module tb_fir_mac_serial;
    localparam int TA = 6;
    localparam int TB = 4;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic busy_a, busy_b;
    int n_chk = 0;
    int n_pass = 0;
    int xa[$], ha[$], xb[$], hb[$];

    fir_mac_serial_if #(.TAPS(TA)) ia ();
    fir_mac_serial_if #(.TAPS(TB)) ib ();

    fir_mac_serial #(.DATA_W(8), .COEF_W(8), .TAPS(TA), .OUT_W(8), .OUT_SHIFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave), .busy(busy_a)
    );
    fir_mac_serial #(.DATA_W(8), .COEF_W(8), .TAPS(TB), .OUT_W(8), .OUT_SHIFT(SB)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // y = clamp(floor((sum x[k]*h[k] + bias) / 2^sh)) into signed 8 bits
    function automatic void ref_out(input int xs[$], input int hs[$], input int sh, output int y, output bit s);
        longint a = 0;
        for (int i = 0; i < xs.size(); i++) a += longint'(xs[i]) * longint'(hs[i]);
`ifdef FIR_ROUND_EN
        if (sh > 0) a += longint'(1) << (sh - 1);
`endif
        a = a >>> sh;
        s = a > 127 || a < -128;
        y = s ? (a > 0 ? 127 : -128) : int'(a);
    endfunction

    task automatic model_reset();
        xa = {}; ha = {}; xb = {}; hb = {};
        for (int i = 0; i < TA; i++) begin xa.push_back(0); ha.push_back(i == 0 ? 1 : 0); end
        for (int i = 0; i < TB; i++) begin xb.push_back(0); hb.push_back(i == 0 ? 1 : 0); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2 model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wcoef_a(input int addr, input int val);
        ia.coef_we = 1'b1; ia.coef_addr = 3'(addr); ia.coef_wdata = 8'(val);
        @(posedge clk);
        #1 ia.coef_we = 1'b0;
        if (addr < TA) ha[addr] = val;
        chk("coef_idle_drop", ia.coef_drop, 0);
    endtask

    // wa >= 0 issues a coefficient write two cycles into the MAC pass
    task automatic feed_a(input int v, input int bp, input int wa, input int wd, input string tag);
        int n, ye;
        bit s;
        bit ready_low = 1'b1;
        logic signed [7:0] held;
        chk({tag, ".in_ready"}, ia.in_ready, 1);
        ia.in_valid = 1'b1; ia.in_data = 8'(v);
        @(posedge clk);
        #1 ia.in_valid = 1'b0; ia.coef_we = 1'b0; ia.in_data = '0;
        xa.push_front(v); void'(xa.pop_back());
        ref_out(xa, ha, 0, ye, s);
        n = 1;
        while (!ia.out_valid && n < 50) begin
            if (ia.in_ready) ready_low = 1'b0;
            if (wa >= 0 && n == 2) begin ia.coef_we = 1'b1; ia.coef_addr = 3'(wa); ia.coef_wdata = 8'(wd); end
            @(posedge clk);
            #1 ia.coef_we = 1'b0;
            if (wa >= 0 && n == 2) chk({tag, ".drop"}, ia.coef_drop, wa < TA);
            if (wa >= 0 && n == 3) chk({tag, ".drop_end"}, ia.coef_drop, 0);
            n++;
        end
        chk({tag, ".latency"}, n, TA + 1);
        chk({tag, ".in_ready_low"}, ready_low, 1);
        chk({tag, ".out_in_ready"}, ia.in_ready, 0);
        chk({tag, ".data"}, ia.out_data, ye);
        chk({tag, ".sat"}, ia.out_sat, s);
        held = ia.out_data;
        for (int i = 0; i < bp; i++) begin
            ia.in_valid = 1'b1; ia.in_data = 8'sd99;
            @(posedge clk);
            #1 ia.in_valid = 1'b0;
            chk({tag, ".hold"}, ia.out_data, held);
            chk({tag, ".hold_valid"}, ia.out_valid, 1);
        end
        ia.out_ready = 1'b1;
        @(posedge clk);
        #1 ia.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, ia.out_valid, 0);
    endtask

    task automatic feed_b(input int v, input string tag);
        int n, ye;
        bit s;
        ib.in_valid = 1'b1; ib.in_data = 8'(v);
        @(posedge clk);
        #1 ib.in_valid = 1'b0;
        xb.push_front(v); void'(xb.pop_back());
        ref_out(xb, hb, SB, ye, s);
        n = 1;
        while (!ib.out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, ".latency"}, n, TB + 1);
        chk({tag, ".data"}, ib.out_data, ye);
        chk({tag, ".sat"}, ib.out_sat, s);
        ib.out_ready = 1'b1;
        @(posedge clk);
        #1 ib.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        ia.in_valid = 0; ia.in_data = 0; ia.coef_we = 0; ia.coef_addr = 0; ia.coef_wdata = 0; ia.out_ready = 0;
        ib.in_valid = 0; ib.in_data = 0; ib.coef_we = 0; ib.coef_addr = 0; ib.coef_wdata = 0; ib.out_ready = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst.in_ready", ia.in_ready, 1);
        chk("rst.out_valid", ia.out_valid, 0);
        chk("rst.out_data", ia.out_data, 0);
        chk("rst.out_sat", ia.out_sat, 0);
        chk("rst.coef_drop", ia.coef_drop, 0);
        chk("rst.busy", busy_a, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        feed_a(5, 0, -1, 0, "bypass");

        do_reset();
        for (int i = 0; i < TA; i++) wcoef_a(i, 1);
        feed_a(10, 0, -1, 0, "avg0");
        feed_a(20, 0, -1, 0, "avg1");
        feed_a(30, 0, -1, 0, "avg2");
        for (int i = 0; i < 5; i++) feed_a(10, 0, -1, 0, "avg_tail");

        wcoef_a(0, 127);
        for (int i = 1; i < TA; i++) wcoef_a(i, 0);
        feed_a(127, 0, -1, 0, "sat_pos");
        feed_a(-128, 0, -1, 0, "sat_neg");

        wcoef_a(0, 1);
        feed_a(9, 5, -1, 0, "backpressure");
        for (int i = 0; i < TA; i++) wcoef_a(i, 1);
        feed_a(0, 0, -1, 0, "line_intact");

        for (int i = 0; i < TA; i++) wcoef_a(i, i == 0 ? 1 : 0);
        feed_a(4, 0, 0, 3, "mac_write");
        feed_a(4, 0, 7, 3, "mac_write_oob");
        wcoef_a(7, 55);
        feed_a(-3, 0, -1, 0, "idle_write_oob");

        ia.coef_we = 1'b1; ia.coef_addr = 3'd0; ia.coef_wdata = 8'sd2;
        ha[0] = 2;
        feed_a(11, 0, -1, 0, "write_with_accept");

        ia.in_valid = 1'b1; ia.in_data = 8'sd50;
        @(posedge clk);
        #1 ia.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", ia.out_valid, 0);
        chk("rst_mid.busy", busy_a, 0);
        chk("rst_mid.in_ready", ia.in_ready, 1);
        chk("rst_mid.out_data", ia.out_data, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        feed_a(7, 0, -1, 0, "post_rst");

        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) wcoef_a(int'($urandom_range(0, 7)), int'($urandom_range(0, 30)) - 15);
            feed_a(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)), -1, 0, "rand");
        end

        feed_b(6, "round_p6");
        feed_b(-6, "round_n6");
        feed_b(2, "round_p2");
        feed_b(-2, "round_n2");
        for (int t = 0; t < 4; t++) feed_b(int'($urandom_range(0, 255)) - 128, "round_rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
